// File: rtl/tick_div_pkg.sv
// rtl/tick_div_pkg.sv - shared types and constants for the multi-channel tick divider
package tick_div_pkg;

    // Per-channel output shape
    typedef enum logic {
        TICK_PULSE  = 1'b0,
        TICK_SQUARE = 1'b1
    } tick_mode_e;

    localparam int unsigned SYS_CLK_HZ       = 50_000_000;
    localparam int unsigned DEFAULT_DIV_1KHZ = 50_000;

    // Width of a channel select; a single channel still gets a 1-bit select
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tick_div_channel.sv
// rtl/tick_div_channel.sv - one divider channel: counter, active/shadow divisor, tick output
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            run enable; low holds the counter at 0 and the tick low
//   mode_i          0 = single-cycle pulse, 1 = square wave
//   sync_i          force a wrap (phase alignment); tie low when unused
//   wr_i            accepted divisor write for this channel
//   wr_div_i        divisor carried by the write (already checked non-zero)
//   tick_o          registered tick
module tick_div_channel
    import tick_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = DEFAULT_DIV_1KHZ
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;      // position inside the current period
    logic [WIDTH-1:0] d_q, d_d;      // active divisor
    logic [WIDTH-1:0] s_q, s_d;      // shadow divisor waiting for the next wrap
    logic             p_q, p_d;      // shadow holds a value not yet applied
    logic             tick_q, tick_d;

    tick_mode_e mode;
    logic       terminal;

    assign mode     = tick_mode_e'(mode_i);
    // d_q is never 0, so d_q-1 never underflows
    assign terminal = (q_q == d_q - ONE);

    always_comb begin
        q_d    = q_q;
        d_d    = d_q;
        s_d    = s_q;
        p_d    = p_q;
        tick_d = 1'b0;

        if (sync_i || !en_i) begin
            // Forced wrap: restart the period and take any pending divisor now
            q_d    = '0;
            tick_d = 1'b0;
            if (p_q) begin
                d_d = s_q;
                p_d = 1'b0;
            end
        end else begin
            if (mode == TICK_SQUARE) begin
                tick_d = (q_q < (d_q >> 1));
            end else begin
                tick_d = terminal;
            end

            if (terminal) begin
                q_d = '0;
                if (p_q) begin
                    d_d = s_q;
                    p_d = 1'b0;
                end
            end else begin
                q_d = q_q + ONE;
            end
        end

        // A write on a wrap cycle lands after the wrap consumed the old shadow,
        // so the new value pends until the following wrap.
        if (wr_i) begin
            s_d = wr_div_i;
            p_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= '0;
            d_q    <= DIV_RST;
            s_q    <= DIV_RST;
            p_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            d_q    <= d_d;
            s_q    <= s_d;
            p_q    <= p_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/tick_divider_multi.sv
// rtl/tick_divider_multi.sv - multi-channel programmable tick divider with write decode
//
// Optional feature macro: TICK_DIVIDER_SYNC_EN (adds the Sync input).
//
// Ports:
//   Clock, Reset_n   system clock, asynchronous active-low reset
//   Enable[C]        per-channel run enable
//   Mode[C]          per-channel mode: 0 = pulse, 1 = square
//   WrEn             divisor write strobe
//   WrSel            target channel of the write
//   WrDiv            new divisor value
//   Sync             (TICK_DIVIDER_SYNC_EN only) restart every channel's period
//   WrAck            one-cycle pulse: write accepted
//   WrErr            one-cycle pulse: write rejected (zero divisor or bad channel)
//   Tick[C]          per-channel registered tick
module tick_divider_multi
    import tick_div_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int WIDTH       = 16,
    parameter  int DEFAULT_DIV = DEFAULT_DIV_1KHZ,
    localparam int SEL_W       = sel_width(CHANNELS)
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [CHANNELS-1:0] Enable,
    input  logic [CHANNELS-1:0] Mode,
    input  logic                WrEn,
    input  logic [SEL_W-1:0]    WrSel,
    input  logic [WIDTH-1:0]    WrDiv,
`ifdef TICK_DIVIDER_SYNC_EN
    input  logic                Sync,
`endif
    output logic                WrAck,
    output logic                WrErr,
    output logic [CHANNELS-1:0] Tick
);

    // One extra bit so CHANNELS itself is representable when it is a power of two
    localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(CHANNELS);

    logic sync;
    logic sel_ok;
    logic div_ok;
    logic wr_ok;
    logic wr_ack_q, wr_err_q;

`ifdef TICK_DIVIDER_SYNC_EN
    assign sync = Sync;
`else
    assign sync = 1'b0;
`endif

    assign sel_ok = ({1'b0, WrSel} < SEL_LIM);
    assign div_ok = |WrDiv;
    assign wr_ok  = WrEn && sel_ok && div_ok;

    // Ack and error are mutually exclusive by construction and last one cycle
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_ok;
            wr_err_q <= WrEn && !wr_ok;
        end
    end

    assign WrAck = wr_ack_q;
    assign WrErr = wr_err_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic ch_wr;

        assign ch_wr = wr_ok && (WrSel == SEL_W'(i));

        tick_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i    (Clock),
            .rst_ni   (Reset_n),
            .en_i     (Enable[i]),
            .mode_i   (Mode[i]),
            .sync_i   (sync),
            .wr_i     (ch_wr),
            .wr_div_i (WrDiv),
            .tick_o   (Tick[i])
        );
    end

endmodule

// File: tb/tb_tick_divider_multi.sv
// tb/tb_tick_divider_multi.sv - self-checking bench for tick_divider_multi
module tb_tick_divider_multi;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int DEF = 12;

    logic          Clock;
    logic          Reset_n;
    logic [CH-1:0] Enable;
    logic [CH-1:0] Mode;
    logic          WrEn;
    logic [1:0]    WrSel;
    logic [W-1:0]  WrDiv;
    logic          Sync;
    logic          WrAck;
    logic          WrErr;
    logic [CH-1:0] Tick;

    int n_cmp = 0;
    int n_bad = 0;

    tick_divider_multi #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Enable  (Enable),
        .Mode    (Mode),
        .WrEn    (WrEn),
        .WrSel   (WrSel),
        .WrDiv   (WrDiv),
`ifdef TICK_DIVIDER_SYNC_EN
        .Sync    (Sync),
`endif
        .WrAck   (WrAck),
        .WrErr   (WrErr),
        .Tick    (Tick)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: each channel remembers its period length, how many cycles of
    // the current period have elapsed, and a divisor queued for the next period.
    int      m_per  [CH];
    int      m_elap [CH];
    int      m_next [CH];
    bit      m_has  [CH];
    bit [CH-1:0] m_tick;
    bit      m_ack, m_err;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_per[c]  = DEF;
            m_elap[c] = 0;
            m_next[c] = DEF;
            m_has[c]  = 1'b0;
        end
        m_tick = '0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        bit ok;
        for (int c = 0; c < CH; c++) begin
            if (!Enable[c] || Sync) begin
                m_tick[c] = 1'b0;
                m_elap[c] = 0;
                if (m_has[c]) begin m_per[c] = m_next[c]; m_has[c] = 1'b0; end
            end else begin
                if (Mode[c]) m_tick[c] = (m_elap[c] < m_per[c] / 2);
                else         m_tick[c] = (m_elap[c] == m_per[c] - 1);
                m_elap[c] = m_elap[c] + 1;
                if (m_elap[c] >= m_per[c]) begin
                    m_elap[c] = 0;
                    if (m_has[c]) begin m_per[c] = m_next[c]; m_has[c] = 1'b0; end
                end
            end
        end
        ok = (WrDiv != 0) && (int'(WrSel) < CH);
        if (WrEn && ok) begin
            m_next[WrSel] = int'(WrDiv);
            m_has[WrSel]  = 1'b1;
        end
        m_ack = WrEn && ok;
        m_err = WrEn && !ok;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, outputs compared at the falling edge
    task automatic cycle();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        chk("tick_model", 32'(Tick), 32'(m_tick));
        chk("ack_model",  32'(WrAck), 32'(m_ack));
        chk("err_model",  32'(WrErr), 32'(m_err));
    endtask

    // Disable the channel, write it, and let the disabled channel adopt it
    task automatic load_div(input int ch, input int div);
        Enable[ch] = 1'b0;
        WrEn  = 1'b1;
        WrSel = 2'(ch);
        WrDiv = W'(div);
        cycle();
        chk("load_ack", 32'(WrAck), 32'd1);
        WrEn = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] div;
        bit           exp_ack;
        bit           exp_err;
    } wr_vec_t;

    wr_vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd0, 8'd5,   1'b1, 1'b0};
        vecs[1] = '{2'd1, 8'd6,   1'b1, 1'b0};
        vecs[2] = '{2'd2, 8'd255, 1'b1, 1'b0};
        vecs[3] = '{2'd0, 8'd0,   1'b0, 1'b1};
        vecs[4] = '{2'd3, 8'd4,   1'b0, 1'b1};
        vecs[5] = '{2'd3, 8'd0,   1'b0, 1'b1};
        vecs[6] = '{2'd2, 8'd1,   1'b1, 1'b0};
        vecs[7] = '{2'd1, 8'd0,   1'b0, 1'b1};

        Reset_n = 1'b0;
        Enable  = '0;
        Mode    = '0;
        WrEn    = 1'b0;
        WrSel   = '0;
        WrDiv   = '0;
        Sync    = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("reset_tick", 32'(Tick), 32'd0);
        chk("reset_ack",  32'(WrAck), 32'd0);
        chk("reset_err",  32'(WrErr), 32'd0);
        Reset_n = 1'b1;

        // Write decode table (all channels idle)
        for (int i = 0; i < 8; i++) begin
            WrEn  = 1'b1;
            WrSel = vecs[i].sel;
            WrDiv = vecs[i].div;
            cycle();
            chk("tbl_ack", 32'(WrAck), 32'(vecs[i].exp_ack));
            chk("tbl_err", 32'(WrErr), 32'(vecs[i].exp_err));
            WrEn = 1'b0;
            cycle();
            chk("tbl_ack_clear", 32'(WrAck), 32'd0);
            chk("tbl_err_clear", 32'(WrErr), 32'd0);
        end

        // Pulse mode, D=5: first tick five cycles after enable, then every 5
        load_div(0, 5);
        Mode[0]   = 1'b0;
        Enable[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycle();
            chk("pulse5", 32'(Tick[0]), 32'((k % 5) == 0));
        end

        // Square mode on ch1: D=6, D=7, D=1
        load_div(1, 6);
        Mode[1]   = 1'b1;
        Enable[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            chk("square6", 32'(Tick[1]), 32'(((k - 1) % 6) < 3));
        end
        load_div(1, 7);
        Enable[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            chk("square7", 32'(Tick[1]), 32'(((k - 1) % 7) < 3));
        end
        load_div(1, 1);
        Enable[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            chk("square1", 32'(Tick[1]), 32'd0);
        end

        // Reprogram mid-period: D=10, write 3 at Q=4; period finishes at 10, then 3
        load_div(0, 10);
        Mode[0]   = 1'b0;
        Enable[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                WrEn = 1'b1; WrSel = 2'd0; WrDiv = 8'd3;
            end
            cycle();
            WrEn = 1'b0;
            if (k == 5) chk("midwrite_ack", 32'(WrAck), 32'd1);
            chk("midwrite_tick", 32'(Tick[0]), 32'((k == 10) || (k > 10 && ((k - 10) % 3) == 0)));
        end

`ifdef TICK_DIVIDER_SYNC_EN
        // Sync phase-aligns ch0 (D=4) and ch1 (D=8)
        load_div(0, 4);
        load_div(1, 8);
        Mode   = '0;
        Enable = 3'b011;
        repeat (3) cycle();
        Sync = 1'b1;
        cycle();
        chk("sync_tick_low", 32'(Tick[1:0]), 32'd0);
        Sync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            chk("sync_ch0", 32'(Tick[0]), 32'((k % 4) == 0));
            chk("sync_ch1", 32'(Tick[1]), 32'((k % 8) == 0));
        end
`endif

        // Reset mid-count with a pending write
        load_div(0, 10);
        Enable = 3'b001;
        Mode   = 3'b001;
        cycle();
        WrEn = 1'b1; WrSel = 2'd0; WrDiv = 8'd7;
        cycle();
        WrEn = 1'b0;
        cycle();
        chk("prereset_tick", 32'(Tick[0]), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("async_reset_tick", 32'(Tick), 32'd0);
        chk("async_reset_ack",  32'(WrAck), 32'd0);
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            chk("post_reset_default", 32'(Tick[0]), 32'(((k - 1) % DEF) < (DEF / 2)));
        end

        // Randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) Enable = 3'($urandom);
            if ($urandom_range(0, 7) == 0)  Mode   = 3'($urandom);
            WrEn  = ($urandom_range(0, 3) == 0);
            WrSel = 2'($urandom_range(0, 3));
            WrDiv = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
`ifdef TICK_DIVIDER_SYNC_EN
            Sync  = ($urandom_range(0, 63) == 0);
`endif
            cycle();
        end
        WrEn = 1'b0;
        Sync = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
